// File: rtl/replay_receiver_pkg.sv
// -----------------------------------------------------------------------------
// replay_receiver_pkg
//   Shared mesh-link types for the replay receiver.
//   - rx_state_t      : receiver state (RUN, NACK_PEND, DISCARD)
//   - replay_rx_out_t : ack/ack_count/nack bundle returned to the sender. Its
//                       fields line up with the ack/ack_count/nack fields of
//                       the sender's replay buffer input.
//   - MESH_BUFFER_SIZE / MESH_SEQ_W : mesh replay depth and sequence width.
// -----------------------------------------------------------------------------
package replay_receiver_pkg;

  localparam int MESH_BUFFER_SIZE = 16;
  localparam int MESH_SEQ_W       = $clog2(MESH_BUFFER_SIZE);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    NACK_PEND = 2'd1,
    DISCARD   = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic                  ack;
    logic [MESH_SEQ_W-1:0] ack_count;
    logic                  nack;
  } replay_rx_out_t;

  // Sequence numbers wrap modulo 2^SEQ_W, so a plain increment is enough.
  function automatic logic [MESH_SEQ_W-1:0] seq_next(input logic [MESH_SEQ_W-1:0] seq);
    return seq + {{(MESH_SEQ_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/replay_receiver_ack.sv
// -----------------------------------------------------------------------------
// replay_ack_coalescer
//   Counts packets accepted since the last ack and decides when to return an
//   ack to the sender.
//   Ports:
//     clk, nreset    clock, synchronous active-high reset
//     flush          receiver is in NACK_PEND: ack any pending count at once
//     accept         a packet is accepted this cycle
//     ack            one-cycle ack pulse (from registered state only)
//     ack_count      packets covered by this ack (registered pending count)
//     pending_zero   no packets are waiting for an ack
// -----------------------------------------------------------------------------
module replay_ack_coalescer #(
  parameter int SEQ_W         = 4,
  parameter int ACK_THRESHOLD = 4,
  parameter int ACK_TIMEOUT   = 32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             flush,
  input  logic             accept,
  output logic             ack,
  output logic [SEQ_W-1:0] ack_count,
  output logic             pending_zero
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  logic [SEQ_W-1:0] pending;
  logic [SEQ_W-1:0] pending_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic             fire;
  logic [SEQ_W-1:0] accept_inc;

  assign accept_inc = {{(SEQ_W-1){1'b0}}, accept};

  // Ack decision and next pending/timer values.
  always_comb begin
    fire         = 1'b0;
    pending_next = pending;
    timer_next   = timer;
    if (flush) begin
      fire = (pending != {SEQ_W{1'b0}});
    end else begin
      fire = (pending >= SEQ_W'(ACK_THRESHOLD)) ||
             ((pending != {SEQ_W{1'b0}}) && (timer == TMR_W'(ACK_TIMEOUT - 1)));
    end
    if (fire) begin
      // A packet taken in the ack cycle opens the next batch.
      pending_next = accept_inc;
      timer_next   = {TMR_W{1'b0}};
    end else begin
      pending_next = pending + accept_inc;
      if (pending != {SEQ_W{1'b0}}) begin
        timer_next = timer + TMR_W'(1);
      end else begin
        timer_next = {TMR_W{1'b0}};
      end
    end
  end

  // Pending count and timeout counter registers.
  always_ff @(posedge clk) begin
    if (nreset) begin
      pending <= {SEQ_W{1'b0}};
      timer   <= {TMR_W{1'b0}};
    end else begin
      pending <= pending_next;
      timer   <= timer_next;
    end
  end

  assign ack          = fire;
  assign ack_count    = fire ? pending : {SEQ_W{1'b0}};
  assign pending_zero = (pending == {SEQ_W{1'b0}});

endmodule

// File: rtl/replay_receiver.sv
// -----------------------------------------------------------------------------
// replay_receiver
//   Far-end partner of the mesh link replay buffer. Accepts in-order,
//   sequence-numbered packets go-back-N style, forwards them through a
//   one-entry output register and returns coalesced acks and nacks.
//   Optional feature macro: REPLAY_RX_PARITY_EN -- when defined, a packet must
//   also carry correct even parity (^{in_packet,in_parity}==0) to be accepted.
//   Ports:
//     clk, nreset             clock, synchronous active-high reset
//     in_valid/in_seq/in_packet/in_parity   link packet
//     link_ready              !out_valid || out_ready; sender sends only when high
//     out_valid/out_packet/out_ready        downstream handshake
//     ack/ack_count           coalesced ack pulse and its packet count
//     nack                    rewind request to the sender
//     drop_count              saturating count of discarded packets
// -----------------------------------------------------------------------------
module replay_receiver
  import replay_receiver_pkg::*;
#(
  parameter int BUFFER_SIZE   = 16,
  parameter int PACKET_WIDTH  = 64,
  parameter int ACK_THRESHOLD = 4,
  parameter int ACK_TIMEOUT   = 32,
  parameter int NACK_RETRY    = 64
) (
  input  logic                              clk,
  input  logic                              nreset,
  input  logic                              in_valid,
  input  logic [$clog2(BUFFER_SIZE)-1:0]    in_seq,
  input  logic [PACKET_WIDTH-1:0]           in_packet,
  input  logic                              in_parity,
  output logic                              link_ready,
  output logic                              out_valid,
  output logic [PACKET_WIDTH-1:0]           out_packet,
  input  logic                              out_ready,
  output logic                              ack,
  output logic [$clog2(BUFFER_SIZE)-1:0]    ack_count,
  output logic                              nack,
  output logic [15:0]                       drop_count
);

  localparam int SEQ_W   = $clog2(BUFFER_SIZE);
  localparam int RETRY_W = $clog2(NACK_RETRY + 1);

  // The ack bundle is shared with the sender, so the depth must match the mesh.
  if (SEQ_W != MESH_SEQ_W) begin : g_seq_w_check
    $error("replay_receiver: BUFFER_SIZE does not match the mesh sequence width");
  end
  if ((ACK_THRESHOLD < 1) || (ACK_THRESHOLD > BUFFER_SIZE - 1)) begin : g_thr_check
    $error("replay_receiver: ACK_THRESHOLD must lie in 1..BUFFER_SIZE-1");
  end

  rx_state_t        state;
  rx_state_t        state_next;
  logic [SEQ_W-1:0] expected_seq;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_next;
  logic             packet_ok;
  logic             good;
  logic             accept;
  logic             drop;
  logic             nack_fire;
  logic             flush;
  logic             coal_ack;
  logic [SEQ_W-1:0] coal_count;
  logic             pending_zero;
  replay_rx_out_t   rx_out;

`ifdef REPLAY_RX_PARITY_EN
  function automatic logic parity_ok(input logic [PACKET_WIDTH-1:0] pkt, input logic par);
    return ~(^{pkt, par});
  endfunction

  assign packet_ok = parity_ok(in_packet, in_parity);
`else
  logic parity_unused;
  assign parity_unused = in_parity;
  assign packet_ok     = 1'b1;
`endif

  assign link_ready = !out_valid || out_ready;
  assign good       = in_valid && link_ready && (in_seq == expected_seq) && packet_ok;
  assign flush      = (state == NACK_PEND);

  // Receiver state machine: accept/drop decision and nack generation.
  always_comb begin
    state_next = state;
    retry_next = retry;
    accept     = 1'b0;
    drop       = 1'b0;
    nack_fire  = 1'b0;
    case (state)
      RUN: begin
        if (good) begin
          accept = 1'b1;
        end else if (in_valid) begin
          drop       = 1'b1;
          state_next = NACK_PEND;
        end else begin
          state_next = RUN;
        end
      end
      NACK_PEND: begin
        drop = in_valid;
        // Outstanding acks are flushed first so ack and nack never coincide.
        if (pending_zero) begin
          nack_fire  = 1'b1;
          state_next = DISCARD;
          retry_next = {RETRY_W{1'b0}};
        end else begin
          state_next = NACK_PEND;
        end
      end
      DISCARD: begin
        if (good) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          drop = in_valid;
          if (retry == RETRY_W'(NACK_RETRY - 1)) begin
            state_next = NACK_PEND;
          end else begin
            retry_next = retry + RETRY_W'(1);
          end
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, sequence tracking, output stage and drop counter.
  always_ff @(posedge clk) begin
    if (nreset) begin
      state        <= RUN;
      retry        <= {RETRY_W{1'b0}};
      expected_seq <= {SEQ_W{1'b0}};
      out_valid    <= 1'b0;
      out_packet   <= {PACKET_WIDTH{1'b0}};
      drop_count   <= 16'h0000;
    end else begin
      state <= state_next;
      retry <= retry_next;
      if (accept) begin
        expected_seq <= seq_next(expected_seq);
        out_valid    <= 1'b1;
        out_packet   <= in_packet;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'h0001;
      end
    end
  end

  replay_ack_coalescer #(
    .SEQ_W         (SEQ_W),
    .ACK_THRESHOLD (ACK_THRESHOLD),
    .ACK_TIMEOUT   (ACK_TIMEOUT)
  ) u_ack (
    .clk          (clk),
    .nreset       (nreset),
    .flush        (flush),
    .accept       (accept),
    .ack          (coal_ack),
    .ack_count    (coal_count),
    .pending_zero (pending_zero)
  );

  assign rx_out.ack       = coal_ack;
  assign rx_out.ack_count = coal_count;
  assign rx_out.nack      = nack_fire;

  assign ack       = rx_out.ack;
  assign ack_count = rx_out.ack_count;
  assign nack      = rx_out.nack;

endmodule

// File: tb/tb_replay_receiver.sv
module tb_replay_receiver;

  localparam int BUFFER_SIZE   = 16;
  localparam int PACKET_WIDTH  = 64;
  localparam int ACK_THRESHOLD = 4;
  localparam int ACK_TIMEOUT   = 32;
  localparam int NACK_RETRY    = 64;
`ifdef REPLAY_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int M_RUN = 0, M_NACK = 1, M_DISCARD = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_seq = 4'd0;
  logic [63:0] in_packet = 64'd0;
  logic        in_parity = 1'b0;
  logic        link_ready;
  logic        out_valid;
  logic [63:0] out_packet;
  logic        out_ready = 1'b1;
  logic        ack;
  logic [3:0]  ack_count;
  logic        nack;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  replay_receiver #(
    .BUFFER_SIZE(BUFFER_SIZE), .PACKET_WIDTH(PACKET_WIDTH), .ACK_THRESHOLD(ACK_THRESHOLD),
    .ACK_TIMEOUT(ACK_TIMEOUT), .NACK_RETRY(NACK_RETRY)
  ) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_seq(in_seq), .in_packet(in_packet),
    .in_parity(in_parity), .link_ready(link_ready), .out_valid(out_valid), .out_packet(out_packet),
    .out_ready(out_ready), .ack(ack), .ack_count(ack_count), .nack(nack), .drop_count(drop_count)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // ---------------- reference model (spec-level receiver behaviour) ----------
  typedef struct { int cyc; int cnt; } ack_ev_t;
  ack_ev_t     ack_q[$];
  int          nack_q[$];
  logic [63:0] pkt_q[$];

  int m_mode, m_expect, m_pending, m_wait, m_retry, m_drops, m_drops_vis;
  bit m_outv, m_outv_vis, m_link_now;
  bit ev_ack, ev_nack;
  int ev_cnt;

  task automatic model_reset();
    m_mode = M_RUN; m_expect = 0; m_pending = 0; m_wait = 0; m_retry = 0;
    m_drops = 0; m_drops_vis = 0; m_outv = 0; m_outv_vis = 0; m_link_now = 1;
    ev_ack = 0; ev_nack = 0; ev_cnt = 0;
  endtask

  // One cycle of the receiver as described by its rules: which presented
  // packets are taken, when acks and nacks go out, and what is dropped.
  task automatic model_step(input bit v, input int seq, input logic [63:0] pkt,
                            input bit par, input bit rdy);
    bit good, fire, take;
    m_drops_vis = m_drops;
    m_outv_vis  = m_outv;
    m_link_now  = !m_outv || rdy;
    good = v && m_link_now && (seq == m_expect);
    if (PAR_EN && ((^pkt) != par)) good = 0;
    if (m_mode == M_NACK) fire = (m_pending > 0);
    else fire = (m_pending >= ACK_THRESHOLD) || (m_pending > 0 && m_wait == ACK_TIMEOUT - 1);
    ev_ack = fire; ev_cnt = m_pending; ev_nack = 0;
    if (fire) ack_q.push_back('{cyc, m_pending});
    take = 0;
    if (m_mode == M_RUN) begin
      if (good) take = 1;
      else if (v) m_mode = M_NACK;
    end else if (m_mode == M_NACK) begin
      if (m_pending == 0) begin
        ev_nack = 1; nack_q.push_back(cyc); m_mode = M_DISCARD; m_retry = 0;
      end
    end else begin
      if (good) begin take = 1; m_mode = M_RUN; end
      else if (m_retry == NACK_RETRY - 1) m_mode = M_NACK;
      else m_retry++;
    end
    if (fire) begin m_pending = take; m_wait = 0; end
    else begin
      if (m_pending > 0) m_wait++;
      m_pending += take;
    end
    if (take) begin
      pkt_q.push_back(pkt);
      m_expect = (m_expect + 1) % BUFFER_SIZE;
      m_outv = 1;
    end else if (rdy) m_outv = 0;
    if (v && !take && m_drops < 65535) m_drops++;
  endtask

  // ---------------- monitor --------------------------------------------------
  int ack_seen = 0, nack_seen = 0, last_ack_count = 0, last_ack_cycle = 0;

  always @(negedge clk) begin
    bit exp_ack, exp_nack;
    ack_ev_t ev;
    if (!in_reset) begin
      exp_ack = (ack_q.size() > 0) && (ack_q[0].cyc == cyc);
      if (ack || exp_ack) begin
        check("ack_pulse", ack, exp_ack);
        if (exp_ack) begin
          ev = ack_q.pop_front();
          if (ack) check("ack_count", ack_count, ev.cnt);
        end
      end
      exp_nack = (nack_q.size() > 0) && (nack_q[0] == cyc);
      if (nack || exp_nack) begin
        check("nack_pulse", nack, exp_nack);
        if (exp_nack) void'(nack_q.pop_front());
      end
      if (ack && nack) check("ack_nack_same_cycle", nack, 1'b0);
      check("out_valid", out_valid, m_outv_vis);
      check("link_ready", link_ready, m_link_now);
      check("drop_count", drop_count, m_drops_vis);
      if (out_valid && out_ready) begin
        if (pkt_q.size() == 0) check("out_valid_unexpected", out_valid, 1'b0);
        else check("out_packet", out_packet, pkt_q.pop_front());
      end
      if (ack) begin ack_seen++; last_ack_count = ack_count; last_ack_cycle = cyc; end
      if (nack) nack_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick(input bit v, input int seq, input logic [63:0] pkt,
                      input bit par, input bit rdy);
    @(posedge clk); #1;
    in_valid = v; in_seq = seq[3:0]; in_packet = pkt; in_parity = par; out_ready = rdy;
    model_step(v, seq, pkt, par, rdy);
  endtask

  task automatic send(input int seq, input logic [63:0] pkt);
    tick(1'b1, seq, pkt, ^pkt, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 0, 64'd0, 1'b0, 1'b1);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    in_reset = 1; nreset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    nreset = 1'b0;
    model_reset();
    ack_q.delete(); nack_q.delete(); pkt_q.delete();
    in_reset = 0;
    settle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_nack", nack, 1'b0);
    check("rst_ack_count", ack_count, 4'd0);
    check("rst_drop_count", drop_count, 16'd0);
    check("rst_link_ready", link_ready, 1'b1);
  endtask

  int a0, n0, t0;
  logic [63:0] hold_pkt;
  int base_abs, next_abs, sent_abs, hold;
  logic [63:0] pay [16];

  initial begin
    do_reset();

    // In-order burst: threshold acks after packets 3 and 7.
    do_reset();
    a0 = ack_seen; n0 = nack_seen;
    for (int s = 0; s < 8; s++) send(s, 64'hA000 + 64'(s));
    idle(3); settle();
    check("burst_acks", ack_seen - a0, 2);
    check("burst_last_ack_count", last_ack_count, 4);
    check("burst_nacks", nack_seen - n0, 0);

    // Gap 0,1,3: flush ack of 2, then nack, then replay 2,3.
    do_reset();
    a0 = ack_seen; n0 = nack_seen;
    send(0, 64'hB0); send(1, 64'hB1); send(3, 64'hB3);
    idle(2); settle();
    check("gap_nacks", nack_seen - n0, 1);
    check("gap_flush_ack_count", last_ack_count, 2);
    check("gap_acks", ack_seen - a0, 1);
    send(2, 64'hB2); send(3, 64'hB3);
    idle(2); settle();
    check("gap_drop_count", drop_count, 16'd1);

    // Single packet then idle: timeout ack.
    do_reset();
    a0 = ack_seen;
    send(0, 64'hC0); t0 = cyc;
    idle(ACK_TIMEOUT + 2); settle();
    check("timeout_ack_cycle", last_ack_cycle, t0 + ACK_TIMEOUT);
    check("timeout_ack_count", last_ack_count, 1);
    check("timeout_acks", ack_seen - a0, 1);

    // Sequence wrap 14,15,0 then 1.
    do_reset();
    n0 = nack_seen;
    for (int s = 0; s < 14; s++) send(s, 64'hD000 + 64'(s));
    send(14, 64'hD00E); send(15, 64'hD00F); send(0, 64'hD100); send(1, 64'hD101);
    idle(2); settle();
    check("wrap_drop_count", drop_count, 16'd0);
    check("wrap_nacks", nack_seen - n0, 0);

    // Bad parity bit on seq 0.
    do_reset();
    n0 = nack_seen;
    hold_pkt = 64'h0123_4567_89AB_CDEF;
    tick(1'b1, 0, hold_pkt, ~(^hold_pkt), 1'b1);
    idle(3); settle();
    check("parity_drop_count", drop_count, 16'(PAR_EN));
    check("parity_nacks", nack_seen - n0, 32'(PAR_EN));

    // Downstream stall for 5 cycles.
    do_reset();
    hold_pkt = 64'hDEAD_BEEF_0000_0006;
    tick(1'b1, 0, hold_pkt, ^hold_pkt, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 0, 64'd0, 1'b0, 1'b0); settle();
      check("stall_link_ready", link_ready, 1'b0);
      check("stall_out_packet", out_packet, hold_pkt);
    end
    idle(2);

    // DISCARD: nack retry, then reset while discarding.
    do_reset();
    n0 = nack_seen;
    send(1, 64'hE1);
    idle(2); settle();
    check("discard_first_nack", nack_seen - n0, 1);
    idle(NACK_RETRY + 2); settle();
    check("discard_retry_nack", nack_seen - n0, 2);
    idle(1);
    do_reset();
    send(0, 64'hE0);
    idle(2); settle();
    check("post_reset_drop_count", drop_count, 16'd0);

    // Randomized go-back-N sender against the model.
    do_reset();
    base_abs = 0; next_abs = 0; sent_abs = 0; hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v, par, rdy, adv, link_pred;
      int seq, r;
      logic [63:0] pkt;
      rdy = ($urandom_range(0, 99) < 75);
      if (hold > 0) begin rdy = 0; hold--; end
      else if ($urandom_range(0, 199) == 0) hold = 5;
      v = 0; seq = 0; pkt = 64'd0; par = 0; adv = 0;
      link_pred = !m_outv || rdy;
      if (link_pred) begin
        if ((next_abs - base_abs < 15) && ($urandom_range(0, 99) < 70)) begin
          if (next_abs == sent_abs) begin
            pay[next_abs % 16] = {$urandom, $urandom};
            sent_abs++;
          end
          pkt = pay[next_abs % 16]; seq = next_abs % 16; par = ^pkt; v = 1; adv = 1;
          r = $urandom_range(0, 99);
          if (r < 3) seq = (seq + $urandom_range(1, 15)) % 16;
          else if (r < 6) par = ~par;
        end
      end else if ($urandom_range(0, 99) < 3) begin
        v = 1; seq = $urandom_range(0, 15); pkt = {$urandom, $urandom}; par = ^pkt;
      end
      tick(v, seq, pkt, par, rdy);
      if (adv) next_abs++;
      if (ev_ack) base_abs += ev_cnt;
      if (ev_nack && ($urandom_range(0, 99) < 85)) next_abs = base_abs;
    end
    idle(ACK_TIMEOUT + 8); settle();
    check("end_ack_queue_empty", ack_q.size(), 0);
    check("end_nack_queue_empty", nack_q.size(), 0);
    check("end_packet_queue_empty", pkt_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
